data_sram_responder: RTL and testbench
======================================

// Module: data_sram_responder
// PURPOSE
//  Responder (slave) end of the pipeline's SRAM-like data interface (req/wr/size/wstrb/addr/wdata ->
//  addr_ok/data_ok/rdata). Backed by an internal word-addressed RAM; used as the data-memory model in
//  core-level sims and as a drop-in memory in place of the AXI bridge. Requests are accepted in order,
//  queued, and each one answered with exactly one data_ok pulse after a programmable delay.
// PARAMETERS
//  DEPTH_LOG2   10  log2 of RAM depth in 32-bit words; word index = addr[DEPTH_LOG2+1:2] (upper bits ignored)
//  QDEPTH_LOG2  2   log2 of outstanding-request queue depth (4 entries)
//  DELAY        2   extra cycles between acceptance and data_ok (0..15)
// PORTS
//  clk          in   1   clock, all state on posedge
//  reset        in   1   asynchronous, active-high
//  stall        in   1   test backpressure: forces addr_ok=0 and withholds data_ok while high
//  req          in   1   request valid
//  wr           in   1   1=write, 0=read
//  size         in   2   0=byte 1=half 2=word (alignment check only)
//  wstrb        in   4   byte write enables for writes
//  addr         in   32  byte address
//  wdata        in   32  write data, already lane-replicated by requester
//  addr_ok      out  1   request accepted this cycle when req && addr_ok
//  data_ok      out  1   one-cycle response pulse, oldest outstanding request
//  rdata        out  32  read word (full aligned word); 0 unless data_ok of a read
//  err_misalign out  1   sticky: an accepted request was misaligned
// BEHAVIOUR
//  Reset (async): queue empty, all counters 0, err_misalign=0; data_ok=0, rdata=0. RAM array is NOT
//   reset (contents persist across reset). Outstanding requests at reset are dropped, never answered.
//  addr_ok = !stall && !full (combinational). No push when full, even if a pop occurs the same cycle.
//  Acceptance edge (req && addr_ok): push entry {is_rd, data, cnt=DELAY}.
//   Write: RAM word updated at this edge for each byte with wstrb[i]=1; entry data=0.
//   Read: entry data = RAM word at this edge; read-after-write ordering is strict program order.
//   wr=1 with wstrb=0: accepted, no RAM change, still answered.
//  Each edge every valid entry with cnt>0 decrements by 1 (independent of stall).
//  data_ok = head valid && head.cnt==0 && !stall (combinational); pop on that edge.
//   DELAY=0: data_ok in cycle immediately after acceptance edge; DELAY=d: d cycles later (unless stalled).
//   Back-to-back accepts yield back-to-back data_ok pulses, strictly in order.
//  rdata = data_ok ? head.data : 0.
//  Push and pop same edge: count unchanged; pointers wrap modulo 2^QDEPTH_LOG2.
//  Misalignment: size=1 && addr[0], or size=2 && addr[1:0]!=0, or size=3 -> err_misalign set at
//   acceptance edge, request still served using the aligned word index. Cleared only by reset.
//  req dropped before addr_ok: no state change (requester may retract; no obligation).
//  Throughput: one accept and one response per cycle max.
// TESTING
//  1 reset; write addr 0x10 wdata 0xDEADBEEF wstrb 4'hF; read 0x10 -> data_ok 3 cycles after read accept
//    (DELAY=2), rdata=0xDEADBEEF; write data_ok with rdata=0.
//  2 write 0x20=0x11223344 then byte write wstrb 4'b0100 wdata 0xAAAAAAAA; read 0x20 -> 0x11AA3344.
//  3 hold req with stall=0, DELAY=15: 4 accepts then addr_ok=0 (full); 5th accepted only after first
//    data_ok pop; 5 responses in order.
//  4 stall=1 for 10 cycles with 2 matured entries -> no data_ok; stall=0 -> two consecutive data_ok pulses.
//  5 read size=2 addr 0x22 -> err_misalign=1, rdata = word at 0x20; stays 1 until reset.
//  6 reset mid-flight with 3 outstanding -> data_ok never pulses for them, addr_ok=1 next cycle, RAM
//    data written before reset still readable.

Source files
------------

// File: rtl/data_sram_responder.sv
// SRAM-like data-port responder: in-order request queue with a fixed response delay,
// backed by a byte-writable word RAM whose contents survive reset.
module data_sram_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int QDEPTH_LOG2 = 2,
  parameter int DELAY       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err_misalign
);
  localparam int QD    = 1 << QDEPTH_LOG2;
  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [31:0]            mem   [WORDS];
  logic [31:0]            qdata [QD];
  logic [3:0]             cnt   [QD];
  logic [QD-1:0]          vld;
  logic [QDEPTH_LOG2-1:0] wptr, rptr;
  logic [QDEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2-1:0]  idx;
  logic                   full, push, pop, misalign;
  logic                   unused_addr;

  assign idx         = addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^addr[31:DEPTH_LOG2+2];
  assign full        = count == (QDEPTH_LOG2+1)'(QD);
  assign addr_ok     = !stall && !full;
  assign push        = req && addr_ok;
  assign data_ok     = vld[rptr] && cnt[rptr] == 4'd0 && !stall;
  assign pop         = data_ok;
  assign rdata       = data_ok ? qdata[rptr] : 32'd0;

  always_comb begin
    misalign = 1'b0;
    case (size)
      2'd1:    misalign = addr[0];
      2'd2:    misalign = addr[1:0] != 2'b00;
      2'd3:    misalign = 1'b1;
      default: misalign = 1'b0;
    endcase
  end

  // RAM is deliberately unreset; a write lands on the same edge it is accepted.
  always_ff @(posedge clk) begin
    if (push && wr && !reset) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Read data is captured at acceptance, so later writes never leak into it.
  always_ff @(posedge clk) begin
    if (push) qdata[wptr] <= wr ? 32'd0 : mem[idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld          <= '0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      err_misalign <= 1'b0;
      for (int i = 0; i < QD; i++) cnt[i] <= 4'd0;
    end else begin
      for (int i = 0; i < QD; i++)
        if (vld[i] && cnt[i] != 4'd0) cnt[i] <= cnt[i] - 4'd1;
      if (pop) begin
        vld[rptr] <= 1'b0;
        rptr      <= rptr + 1'b1;
      end
      if (push) begin
        vld[wptr] <= 1'b1;
        cnt[wptr] <= 4'(DELAY);
        wptr      <= wptr + 1'b1;
        if (misalign) err_misalign <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench: two responders (DELAY 2 and 15) on shared stimulus, each checked every cycle
// against a maturity-time queue model, plus directed scenarios.
module tb_data_sram_responder;
  localparam int NI = 2;

  logic clk = 1'b0, reset = 1'b0, stall = 1'b0, req = 1'b0, wr = 1'b0;
  logic [1:0]  size  = 2'd0;
  logic [3:0]  wstrb = 4'd0;
  logic [31:0] addr  = 32'd0, wdata = 32'd0;
  logic [NI-1:0] addr_ok, data_ok, err_misalign;
  logic [31:0]   rdata [NI];

  data_sram_responder #(.DELAY(2)) u_dut0 (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0]),
    .err_misalign(err_misalign[0]));
  data_sram_responder #(.DELAY(15)) u_dut1 (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1]),
    .err_misalign(err_misalign[1]));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: each request becomes a response that is due once the edge count reaches its ready time.
  typedef struct { logic [31:0] data; bit vk; longint ready; } rsp_t;
  rsp_t          mq    [NI][$];
  logic [31:0]   mmem  [NI][1024];
  bit            known [NI][1024];
  bit            merr  [NI];
  longint        ecnt = 0, o_e = 0, acc_e = 0;
  bit            acc   [NI];
  bit            edok  [NI];
  logic [NI-1:0] o_aok, o_dok;
  logic [31:0]   o_rd  [NI];

  function automatic int dly(int i);
    return (i == 0) ? 2 : 15;
  endfunction

  task automatic cycle();
    @(negedge clk);
    o_e = ecnt;
    for (int i = 0; i < NI; i++) begin
      bit e_aok, e_dok, evk;
      logic [31:0] e_rd;
      e_aok = !stall && mq[i].size() < 4;
      e_dok = 1'b0; e_rd = 32'd0; evk = 1'b1;
      if (mq[i].size() > 0 && !stall && ecnt >= mq[i][0].ready) begin
        e_dok = 1'b1; e_rd = mq[i][0].data; evk = mq[i][0].vk;
      end
      o_aok[i] = addr_ok[i]; o_dok[i] = data_ok[i]; o_rd[i] = rdata[i];
      chk($sformatf("addr_ok%0d@%0d", i, ecnt), addr_ok[i], e_aok);
      chk($sformatf("data_ok%0d@%0d", i, ecnt), data_ok[i], e_dok);
      if (evk) chk($sformatf("rdata%0d@%0d", i, ecnt), rdata[i], e_rd);
      chk($sformatf("err%0d@%0d", i, ecnt), err_misalign[i], merr[i]);
      edok[i] = e_dok;
      acc[i]  = req && e_aok && !reset;
    end
    @(posedge clk);
    ecnt++;
    for (int i = 0; i < NI; i++) begin
      if (!reset) begin
        if (edok[i]) void'(mq[i].pop_front());
        if (acc[i]) begin
          int   w;
          rsp_t e;
          w = int'(addr[11:2]);
          if ((addr % (32'd1 << size)) != 0 || size == 2'd3) merr[i] = 1'b1;
          e.ready = ecnt + dly(i);
          if (wr) begin
            for (int b = 0; b < 4; b++) if (wstrb[b]) mmem[i][w][8*b +: 8] = wdata[8*b +: 8];
            if (wstrb == 4'hF) known[i][w] = 1'b1;
            e.data = 32'd0; e.vk = 1'b1;
          end else begin
            e.data = mmem[i][w]; e.vk = known[i][w];
          end
          mq[i].push_back(e);
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    req = 1'b0; stall = 1'b0;
    for (int i = 0; i < NI; i++) begin
      mq[i].delete();
      merr[i] = 1'b0;
    end
    cycle();
    reset = 1'b0;
  endtask

  task automatic issue(bit w, logic [1:0] sz, logic [3:0] st, logic [31:0] a, logic [31:0] d);
    bit done = 1'b0;
    req = 1'b1; wr = w; size = sz; wstrb = st; addr = a; wdata = d;
    for (int t = 0; t < 40 && !done; t++) begin
      cycle();
      done = acc[0];
    end
    acc_e = ecnt;
    req = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output logic [31:0] rd, output longint at);
    bit done = 1'b0;
    rd = 32'd0; at = 0;
    for (int t = 0; t < 40 && !done; t++) begin
      cycle();
      if (o_dok[0]) begin
        done = 1'b1; rd = o_rd[0]; at = o_e;
      end
    end
    if (!done) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && (mq[0].size() != 0 || mq[1].size() != 0); t++) cycle();
    chk("drain_timeout", 32'(mq[0].size() + mq[1].size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    longint at, a, first_full, first_dok, fifth;
    int n_acc, n_dok;

    do_reset();
    chk("reset_rdata0", rdata[0], 32'd0);

    // 1: write then read back, latency and write response
    issue(1'b1, 2'd2, 4'hF, 32'h10, 32'hDEADBEEF);
    wait_rsp(rd, at);
    chk("t1_wr_rdata", rd, 32'd0);
    issue(1'b0, 2'd2, 4'hF, 32'h10, 32'd0);
    a = acc_e;
    wait_rsp(rd, at);
    chk("t1_rd_data", rd, 32'hDEADBEEF);
    chk("t1_latency", 32'(at - (a - 1)), 32'd3);

    // 2: byte-lane merge
    issue(1'b1, 2'd2, 4'hF, 32'h20, 32'h11223344);
    wait_rsp(rd, at);
    issue(1'b1, 2'd0, 4'b0100, 32'h22, 32'hAAAAAAAA);
    wait_rsp(rd, at);
    issue(1'b0, 2'd2, 4'hF, 32'h20, 32'd0);
    wait_rsp(rd, at);
    chk("t2_merge", rd, 32'h11AA3344);

    // 3: fill the DELAY=15 queue with req held
    drain();
    n_acc = 0; first_full = -1; first_dok = -1; fifth = -1;
    req = 1'b1; wr = 1'b0; size = 2'd2; wstrb = 4'hF; addr = 32'h30;
    for (int t = 0; t < 60 && fifth < 0; t++) begin
      cycle();
      if (o_aok[1]) begin
        n_acc++;
        if (n_acc == 5) fifth = o_e;
      end else if (first_full < 0) begin
        first_full = o_e;
        chk("t3_accepts_before_full", 32'(n_acc), 32'd4);
      end
      if (o_dok[1] && first_dok < 0) first_dok = o_e;
    end
    req = 1'b0;
    chk("t3_fifth_after_pop", 32'(fifth - first_dok), 32'd1);
    drain();

    // 4: matured entries held back by stall
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h20;
    cycle(); chk("t4_acc_a", o_aok[0], 1'b1);
    cycle(); chk("t4_acc_b", o_aok[0], 1'b1);
    req = 1'b0; stall = 1'b1; n_dok = 0;
    for (int t = 0; t < 10; t++) begin
      cycle();
      n_dok += int'(o_dok[0]);
    end
    chk("t4_no_dok_stalled", 32'(n_dok), 32'd0);
    stall = 1'b0;
    cycle(); chk("t4_dok_a", {o_dok[0], o_rd[0]}, {1'b1, 32'h11AA3344});
    cycle(); chk("t4_dok_b", {o_dok[0], o_rd[0]}, {1'b1, 32'h11AA3344});
    drain();

    // 5: misaligned word read
    issue(1'b0, 2'd2, 4'hF, 32'h22, 32'd0);
    wait_rsp(rd, at);
    chk("t5_rdata", rd, 32'h11AA3344);
    chk("t5_err", err_misalign[0], 1'b1);

    // randomized traffic away from the directed words
    for (int n = 0; n < 400; n++) begin
      req   = $urandom_range(0, 3) != 0;
      wr    = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      wstrb = 4'($urandom);
      addr  = 32'h40 + 32'($urandom_range(0, 63));
      wdata = $urandom;
      stall = $urandom_range(0, 7) == 0;
      cycle();
    end
    req = 1'b0; stall = 1'b0;
    drain();
    chk("t5_err_sticky", err_misalign[0], 1'b1);

    // 6: reset with requests in flight
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h20;
    for (int t = 0; t < 3; t++) cycle();
    req = 1'b0;
    chk("t6_outstanding", 32'(mq[0].size()), 32'd3);
    do_reset();
    cycle();
    chk("t6_aok_after_reset", o_aok[0], 1'b1);
    chk("t6_err_cleared", err_misalign[0], 1'b0);
    n_dok = 0;
    for (int t = 0; t < 20; t++) begin
      cycle();
      n_dok += int'(o_dok[0]) + int'(o_dok[1]);
    end
    chk("t6_dropped", 32'(n_dok), 32'd0);
    issue(1'b0, 2'd2, 4'hF, 32'h10, 32'd0);
    wait_rsp(rd, at);
    chk("t6_ram_kept_10", rd, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 4'hF, 32'h20, 32'd0);
    wait_rsp(rd, at);
    chk("t6_ram_kept_20", rd, 32'h11AA3344);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
